// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial input and FIFO read-side bus of uart_rx_fifo
//   rx        serial line into the receiver (idle high)
//   rd_en     pop request from the consumer
//   rd_data   FIFO head byte (first-word-fall-through)
//   empty/full/count  FIFO occupancy
//   frame_err/overrun one-clk error pulses
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          rx;
    logic                          rd_en;
    logic [7:0]                    rd_data;
    logic                          empty;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          frame_err;
    logic                          overrun;
    modport master (output rx, rd_en, input rd_data, empty, full, count, frame_err, overrun);
    modport slave  (input rx, rd_en, output rd_data, empty, full, count, frame_err, overrun);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver feeding a first-word-fall-through FIFO
//   clk  system clock, rst  synchronous active-high reset
//   bus  uart_rx_fifo_if.slave: rx in, rd_en in, rd_data/empty/full/count/frame_err/overrun out
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_rx_fifo_if.slave      bus
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t          state_q, state_d;
    logic            s1_q, rxs_q, prev_q;
    logic [DW-1:0]   div_q, div_d;
    logic [TW-1:0]   tck_q, tck_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      smp_q, smp_d;
    logic [7:0]      sh_q, sh_d;
    logic            push, fe_d, fe_q, ov_q;
    logic            tick, decide, last, maj, wr, pop, full;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q;
    assign tick   = state_q != IDLE && div_q == DW'(DIV - 1);
    assign decide = tick && tck_q == TW'(OVERSAMPLE / 2 + 1);
    assign last   = tick && tck_q == TW'(OVERSAMPLE - 1);
    // two earlier samples plus the live one at the decision tick
    assign maj    = (smp_q[0] & smp_q[1]) | (rxs_q & (smp_q[0] | smp_q[1]));
    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || tick) ? '0 : div_q + DW'(1);
        tck_d   = (state_q == IDLE || last) ? '0 : tck_q + TW'(tick);
        bit_d   = state_q == IDLE ? '0 : bit_q;
        smp_d   = (tick && (tck_q == TW'(OVERSAMPLE / 2 - 1) || tck_q == TW'(OVERSAMPLE / 2))) ? {smp_q[0], rxs_q} : smp_q;
        sh_d    = sh_q;
        push    = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            IDLE:  state_d = (prev_q && !rxs_q) ? START : IDLE;
            START: state_d = (decide && maj) ? IDLE : last ? DATA : START;
            DATA: begin
                sh_d = decide ? {maj, sh_q[7:1]} : sh_q;
                bit_d = last ? bit_q + 3'd1 : bit_q;
                state_d = (last && bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: begin
                push = decide && maj;
                fe_d = decide && !maj;
                state_d = !decide ? STOP : maj ? IDLE : BREAK;
            end
            BREAK: state_d = rxs_q ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end
    assign full = cnt_q == CW'(FIFO_DEPTH);
    assign pop  = bus.rd_en && cnt_q != '0;
    // a full FIFO still accepts the byte when the head is popped on the same clk
    assign wr   = push && (!full || bus.rd_en);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s1_q    <= 1'b1;
            rxs_q   <= 1'b1;
            prev_q  <= 1'b1;
            div_q   <= '0;
            tck_q   <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            sh_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= bus.rx;
            rxs_q   <= s1_q;
            prev_q  <= rxs_q;
            div_q   <= div_d;
            tck_q   <= tck_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            sh_q    <= sh_d;
            wp_q    <= wp_q + AW'(wr);
            rp_q    <= rp_q + AW'(pop);
            cnt_q   <= cnt_q + CW'(wr) - CW'(pop);
            fe_q    <= fe_d;
            ov_q    <= push && full && !bus.rd_en;
        end
    end
    always_ff @(posedge clk) begin
        if (wr)
            mem_q[wp_q] <= sh_q;
    end
    assign bus.rd_data   = cnt_q == '0 ? 8'h00 : mem_q[rp_q];
    assign bus.empty     = cnt_q == '0;
    assign bus.full      = full;
    assign bus.count     = cnt_q;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ov_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DIV=4, 64 clks per bit)
module tb_uart_rx_fifo;
    localparam int BIT = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   fe_n = 0;
    int   ov_n = 0;
    uart_rx_fifo_if #(.FIFO_DEPTH(4)) bus ();
    uart_rx_fifo #(
        .CLK_FREQ(1_000_000),
        .BAUD(15625),
        .OVERSAMPLE(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.frame_err) fe_n++;
        if (bus.overrun) ov_n++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_empty"}, 32'(bus.empty), 1);
        check({tag, "_full"}, 32'(bus.full), 0);
        check({tag, "_count"}, 32'(bus.count), 0);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 0);
        check({tag, "_frame_err"}, 32'(bus.frame_err), 0);
        check({tag, "_overrun"}, 32'(bus.overrun), 0);
    endtask
    // one 640-clk frame; clk 618/619 straddle the stop-bit decision edge
    task automatic send(input logic [7:0] d, input logic stop, input bit probe, input bit pop_at, input int abort_at);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10 * BIT; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                bus.rx = 1'b1;
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            bus.rx = f[i / BIT];
            if (pop_at) bus.rd_en = (i == 618);
            if (probe && i == 618) check("pre_decision_empty", 32'(bus.empty), 1);
            if (probe && i == 619) begin
                check("post_decision_empty", 32'(bus.empty), 0);
                check("post_decision_data", 32'(bus.rd_data), 32'(d));
            end
        end
    endtask
    task automatic pop_chk(input string tag, input logic [7:0] exp);
        check(tag, 32'(bus.rd_data), 32'(exp));
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask
    initial begin
        logic [7:0] seq [5];
        seq = '{8'h54, 8'h65, 8'h6D, 8'h70, 8'h20};
        bus.rx = 1'b1;
        bus.rd_en = 1'b0;
        repeat (4) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (BIT) @(negedge clk);
        send(8'h32, 1'b1, 1'b1, 1'b0, -1);
        check("f32_count", 32'(bus.count), 1);
        check("f32_frame_err", 32'(fe_n), 0);
        check("f32_overrun", 32'(ov_n), 0);
        pop_chk("f32_pop", 8'h32);
        check("f32_empty_after_pop", 32'(bus.empty), 1);
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        check("underflow_count", 32'(bus.count), 0);
        bus.rx = 1'b0;
        repeat (12) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("false_start_count", 32'(bus.count), 0);
        check("false_start_frame_err", 32'(fe_n), 0);
        send(8'h55, 1'b0, 1'b0, 1'b0, -1);
        repeat (2 * BIT) @(negedge clk);
        check("break_count", 32'(bus.count), 0);
        bus.rx = 1'b1;
        repeat (BIT) @(negedge clk);
        check("break_frame_err", 32'(fe_n), 1);
        send(8'h41, 1'b1, 1'b0, 1'b0, -1);
        check("after_break_count", 32'(bus.count), 1);
        pop_chk("after_break_data", 8'h41);
        for (int k = 0; k < 4; k++) send(seq[k], 1'b1, 1'b0, 1'b0, -1);
        check("fill_overrun", 32'(ov_n), 0);
        check("fill_full", 32'(bus.full), 1);
        send(seq[4], 1'b1, 1'b0, 1'b0, -1);
        check("ovr_count", 32'(bus.count), 4);
        check("ovr_pulse", 32'(ov_n), 1);
        for (int k = 0; k < 4; k++) pop_chk($sformatf("ovr_read%0d", k), seq[k]);
        check("ovr_empty", 32'(bus.empty), 1);
        check("ovr_empty_data", 32'(bus.rd_data), 0);
        for (int k = 0; k < 4; k++) send(seq[k], 1'b1, 1'b0, 1'b0, -1);
        send(seq[4], 1'b1, 1'b0, 1'b1, -1);
        check("pp_count", 32'(bus.count), 4);
        check("pp_full", 32'(bus.full), 1);
        check("pp_overrun", 32'(ov_n), 1);
        for (int k = 1; k < 5; k++) pop_chk($sformatf("pp_read%0d", k), seq[k]);
        check("pp_empty", 32'(bus.empty), 1);
        send(8'h77, 1'b1, 1'b0, 1'b0, -1);
        check("pre_rst_count", 32'(bus.count), 1);
        send(8'h3C, 1'b1, 1'b0, 1'b0, 5 * BIT + 20);
        check_reset("midframe_rst");
        repeat (BIT) @(negedge clk);
        check("midframe_no_push", 32'(bus.count), 0);
        send(8'h0A, 1'b1, 1'b0, 1'b0, -1);
        check("post_rst_data", 32'(bus.rd_data), 32'h0A);
        check("post_rst_count", 32'(bus.count), 1);
        check("final_frame_err", 32'(fe_n), 1);
        check("final_overrun", 32'(ov_n), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, is the clk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, is the serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, sets sample ticks per bit (even, >=8).
REQ-004 Parameter FIFO_DEPTH, default 4, sets receive FIFO entries (power of two).
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst  input  1  reset: synchronous, active-high.
REQ-007 rx  input  1  asynchronous serial line, idle high; 8N1, LSB first.
REQ-008 rd_en  input  1  pop request; pops the head entry on a clk edge when empty=0.
REQ-009 rd_data  output  8  FIFO head byte (first-word-fall-through).
REQ-010 empty  output  1  FIFO holds no bytes.
REQ-011 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-012 count  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
REQ-013 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-014 overrun  output  1  one-clk pulse: byte received while FIFO full and not popped.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rxs.
REQ-016 A sample tick SHALL pulse for one clk every DIV=CLK_FREQ/(BAUD*OVERSAMPLE) clks (integer division); the divider is held at 0 in IDLE and restarts on leaving IDLE.
REQ-017 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-018 IDLE: a high-to-low transition of rxs moves to START, with the tick counter cleared.
REQ-019 Each bit SHALL span OVERSAMPLE ticks; the bit value is the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 and is decided at tick OVERSAMPLE/2+1.
REQ-020 START: a majority value of 1 (false start) returns to IDLE with no outputs asserted; a value of 0 moves to DATA when the bit period ends.
REQ-021 DATA: 8 bits SHALL be shifted in LSB first; after the 8th bit period, move to STOP.
REQ-022 STOP: on the decided stop value, 1 -> push the byte and go to IDLE on that same clk; 0 -> pulse frame_err, discard the byte, and go to BREAK.
REQ-023 BREAK: remain until rxs=1, then go to IDLE; no falling edge is accepted while in BREAK.
REQ-024 A push SHALL make the byte visible on rd_data and set empty=0 on the clk after the stop decision.
REQ-025 A push while full with rd_en=0 SHALL drop the byte, pulse overrun, and leave the FIFO contents unchanged.
REQ-026 A push while full with rd_en=1 on the same clk SHALL both pop and push: count stays FIFO_DEPTH and overrun stays 0.
REQ-027 A push and a pop on the same clk when not full and not empty SHALL leave count unchanged.
REQ-028 rd_en while empty SHALL be ignored: count does not underflow and pointers do not move.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 full SHALL equal (count==FIFO_DEPTH) and empty SHALL equal (count==0).
REQ-031 rd_data SHALL be 8'h00 whenever empty=1.

Reset
REQ-032 rst SHALL force: state IDLE, synchronizer flops to 1, divider/tick/bit counters to 0, pointers to 0, count=0, empty=1, full=0, rd_data=8'h00, frame_err=0, overrun=0.
REQ-033 rst asserted mid-frame SHALL abandon the partial byte with no push; reception restarts at the next falling edge after rst deasserts.

Verification
(Defaults: DIV=651, one bit = 10416 clks.)
REQ-034 Valid frame 0x32 -> one clk after the stop decision: empty=0, count=1, rd_data=0x32; frame_err=0 and overrun=0 throughout.
REQ-035 rx low pulse of 3 ticks (1953 clks), then rx high -> state returns to IDLE, count=0, no frame_err pulse.
REQ-036 Frame 0x55 with stop bit 0, rx held low 2 further bits, then a valid 0x41 -> exactly one frame_err pulse, no push during the break, then rd_data=0x41 with count=1.
REQ-037 Five back-to-back frames 0x54, 0x65, 0x6D, 0x70, 0x20 with no reads -> full=1, count=4, one overrun pulse at the 5th; reads return 0x54, 0x65, 0x6D, 0x70, then empty=1.
REQ-038 FIFO full, rd_en held high on the clk of the 5th push -> count stays 4, no overrun, head advances to 0x65, tail byte is 0x20.
REQ-039 rst pulsed during data bit 4 of a frame, then valid frame 0x0A -> all outputs at reset values after rst, then rd_data=0x0A, count=1.
